// File: rtl/mc_req_frontend_pkg.sv
// Shared types and sizing for the DDR3 host request front-end.
package mc_req_frontend_pkg;
    localparam int ADDR_W = 31;
    localparam int DATA_W = 128;
    localparam int CMD_W  = ADDR_W + 1;
    localparam int DEPTH  = 8;
    localparam int MAX_RD = 4;

    typedef enum logic {OP_WRITE = 1'b0, OP_READ = 1'b1} op_e;

    typedef struct packed {
        op_e               op;
        logic [ADDR_W-1:0] addr;
    } cmd_t;

    typedef struct packed {
        cmd_t              cmd;
        logic [DATA_W-1:0] data;
    } req_t;

    typedef enum logic [1:0] {ST_IDLE, ST_PRESENT, ST_RD_BLOCK} iss_state_e;
endpackage

// File: rtl/mc_req_frontend_if.sv
// Host request/response and controller command bus of the front-end.
interface mc_req_frontend_if #(parameter int MAX_RD = mc_req_frontend_pkg::MAX_RD);
    import mc_req_frontend_pkg::*;
    localparam int CNT_W = $clog2(MAX_RD + 1);

    logic              req_valid;
    logic              req_ready;
    op_e               req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [CMD_W-1:0]  command;
    logic              valid;
    logic [DATA_W-1:0] write_data;
    logic              ba_cmd_pm;
    logic [DATA_W-1:0] read_data;
    logic              read_data_valid;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [CNT_W-1:0]  rd_outstanding;
    logic              err_unexp_rd;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, ba_cmd_pm, read_data, read_data_valid,
        output req_ready, command, valid, write_data, rsp_valid, rsp_data, rd_outstanding,
               err_unexp_rd
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, ba_cmd_pm, read_data, read_data_valid,
        input  req_ready, command, valid, write_data, rsp_valid, rsp_data, rd_outstanding,
               err_unexp_rd
    );
endinterface

// File: rtl/mc_req_frontend_req_fifo.sv
// In-order request FIFO with wrap-bit pointers; also exposes the head as it will
// look next cycle so the issue FSM can register its state without a bubble.
module req_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] rdata_nxt,
    output logic             empty_nxt,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_comb begin
        wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty_nxt = (wr_ptr_d == rd_ptr_d);
        rdata     = mem_q[rd_ptr_q[AW-1:0]];
        // A push landing on the next head slot means the queue was (or becomes) empty.
        if (push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]))
            rdata_nxt = wdata;
        else
            rdata_nxt = mem_q[rd_ptr_d[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/mc_req_frontend.sv
// Host request front-end for the DDR3 controller: FIFO, issue FSM with a
// read-outstanding cap, registered read responses and an unexpected-data flag.
module mc_req_frontend
    import mc_req_frontend_pkg::*;
#(
    parameter int DEPTH  = mc_req_frontend_pkg::DEPTH,
    parameter int MAX_RD = mc_req_frontend_pkg::MAX_RD
) (
    input  logic                clk,
    input  logic                power_on_rst_n,
    mc_req_frontend_if.slave    bus
);
    localparam int CNT_W = $clog2(MAX_RD + 1);

    iss_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rdy_q, rdy_d;
    logic              err_q, err_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    req_t head, head_nxt, push_req;
    logic full, empty, empty_nxt, push, issue, rd_inc, rd_dec;
    logic unused_nxt;

    assign push_req   = '{cmd: '{op: bus.req_op, addr: bus.req_addr}, data: bus.req_wdata};
    assign unused_nxt = ^{head_nxt.cmd.addr, head_nxt.data, empty};

    req_fifo #(.DEPTH(DEPTH), .WIDTH($bits(req_t))) u_fifo (
        .clk       (clk),
        .rst_n     (power_on_rst_n),
        .push      (push),
        .wdata     (push_req),
        .pop       (issue),
        .rdata     (head),
        .rdata_nxt (head_nxt),
        .empty_nxt (empty_nxt),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        rdy_d       = 1'b1;
        push        = bus.req_valid && rdy_q && !full;
        issue       = (state_q == ST_PRESENT) && bus.ba_cmd_pm;
        rd_inc      = issue && (head.cmd.op == OP_READ);
        rd_dec      = bus.read_data_valid && (cnt_q != '0);
        cnt_d       = cnt_q;
        if (rd_inc && !rd_dec) cnt_d = cnt_q + 1'b1;
        if (!rd_inc && rd_dec) cnt_d = cnt_q - 1'b1;
        err_d       = err_q || (bus.read_data_valid && (cnt_q == '0));
        rsp_valid_d = bus.read_data_valid;
        rsp_data_d  = bus.read_data_valid ? bus.read_data : rsp_data_q;
    end

    // Next state is judged on next cycle's head and count so valid is a plain flop decode.
    always_comb begin
        state_d = ST_PRESENT;
        if (empty_nxt)
            state_d = ST_IDLE;
        else if ((head_nxt.cmd.op == OP_READ) && (cnt_d == CNT_W'(MAX_RD)))
            state_d = ST_RD_BLOCK;
    end

    always_ff @(posedge clk or negedge power_on_rst_n) begin
        if (!power_on_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rdy_q       <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdy_q       <= rdy_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Head contents are masked while idle so stale RAM never leaks after a reset.
    always_comb begin
        bus.req_ready      = rdy_q && !full;
        bus.valid          = (state_q == ST_PRESENT);
        bus.command        = (state_q == ST_IDLE) ? '0 : head.cmd;
        bus.write_data     = ((state_q == ST_IDLE) || (head.cmd.op == OP_READ)) ? '0 : head.data;
        bus.rsp_valid      = rsp_valid_q;
        bus.rsp_data       = rsp_data_q;
        bus.rd_outstanding = cnt_q;
        bus.err_unexp_rd   = err_q;
    end
endmodule

// File: tb/tb_mc_req_frontend.sv
// Directed bench for mc_req_frontend: vector table plus hand sequences for
// full/wrap, read cap, responses and mid-operation reset.
module tb_mc_req_frontend;
    import mc_req_frontend_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    mc_req_frontend_if #(.MAX_RD(4)) bus ();

    mc_req_frontend #(.DEPTH(8), .MAX_RD(4)) dut (
        .clk            (clk),
        .power_on_rst_n (rst_n),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rv;
        logic         op;
        logic [30:0]  addr;
        logic [127:0] wd;
        logic         ba;
        logic         rdv;
        logic [127:0] rd;
        logic         e_rdy;
        logic         e_vld;
        logic [31:0]  e_cmd;
        logic [127:0] e_wd;
        logic         e_rsp;
        logic [127:0] e_rdat;
        logic [2:0]   e_out;
        logic         e_err;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid       = 1'b0;
        bus.req_op          = OP_WRITE;
        bus.req_addr        = '0;
        bus.req_wdata       = '0;
        bus.ba_cmd_pm       = 1'b0;
        bus.read_data       = '0;
        bus.read_data_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push(input logic op, input logic [30:0] a, input logic [127:0] d);
        bus.req_valid = 1'b1;
        bus.req_op    = op_e'(op);
        bus.req_addr  = a;
        bus.req_wdata = d;
    endtask

    function automatic logic [127:0] wdat(input int k);
        return {4{32'hD000_0000 + 32'(k)}};
    endfunction

    initial begin
        logic [127:0] da;
        da = {16{8'hAA}};
        //            rv op addr   wd              ba rdv rd          rdy vld cmd           wd  rsp rdat        out err
        tbl[0] = '{1, 0, 31'h10, da,            1, 0, 128'h0,     1, 1, {1'b0,31'h10}, da,   0, 128'h0,    0, 0};
        tbl[1] = '{0, 0, 31'h0,  128'h0,        1, 0, 128'h0,     1, 0, 32'h0,         '0,   0, 128'h0,    0, 0};
        tbl[2] = '{1, 1, 31'h20, 128'hFFFF,     0, 0, 128'h0,     1, 1, {1'b1,31'h20}, '0,   0, 128'h0,    0, 0};
        tbl[3] = '{0, 0, 31'h0,  128'h0,        1, 0, 128'h0,     1, 0, 32'h0,         '0,   0, 128'h0,    1, 0};
        tbl[4] = '{0, 0, 31'h0,  128'h0,        0, 1, 128'h1234,  1, 0, 32'h0,         '0,   1, 128'h1234, 0, 0};
        tbl[5] = '{0, 0, 31'h0,  128'h0,        0, 0, 128'h0,     1, 0, 32'h0,         '0,   0, 128'h1234, 0, 0};
        tbl[6] = '{0, 0, 31'h0,  128'h0,        0, 1, 128'h55,    1, 0, 32'h0,         '0,   1, 128'h55,   0, 1};
        tbl[7] = '{0, 0, 31'h0,  128'h0,        0, 0, 128'h0,     1, 0, 32'h0,         '0,   0, 128'h55,   0, 1};

        // Reset state
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_rsp",   bus.rsp_valid, 0);
        chk("rst_err",   bus.err_unexp_rd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rel_ready", bus.req_ready, 1);

        // Table: single write, single read, response pulse, unexpected return
        for (int i = 0; i < 8; i++) begin
            bus.req_valid       = tbl[i].rv;
            bus.req_op          = op_e'(tbl[i].op);
            bus.req_addr        = tbl[i].addr;
            bus.req_wdata       = tbl[i].wd;
            bus.ba_cmd_pm       = tbl[i].ba;
            bus.read_data_valid = tbl[i].rdv;
            bus.read_data       = tbl[i].rd;
            tick();
            chk($sformatf("v%0d_ready", i), bus.req_ready, tbl[i].e_rdy);
            chk($sformatf("v%0d_valid", i), bus.valid, tbl[i].e_vld);
            chk($sformatf("v%0d_cmd", i), bus.command, tbl[i].e_cmd);
            chk($sformatf("v%0d_wdata", i), bus.write_data, tbl[i].e_wd);
            chk($sformatf("v%0d_rspv", i), bus.rsp_valid, tbl[i].e_rsp);
            chk($sformatf("v%0d_rspd", i), bus.rsp_data, tbl[i].e_rdat);
            chk($sformatf("v%0d_rdout", i), bus.rd_outstanding, tbl[i].e_out);
            chk($sformatf("v%0d_err", i), bus.err_unexp_rd, tbl[i].e_err);
        end

        // Fill to full under backpressure, pop-without-push on full, in-order drain, wrap
        do_reset();
        for (int k = 0; k < 8; k++) begin
            push(0, 31'h100 + 31'(k), wdat(k));
            tick();
            chk($sformatf("fill%0d_ready", k), bus.req_ready, (k < 7) ? 1 : 0);
            chk($sformatf("fill%0d_cmd", k), bus.command, {1'b0, 31'h100});
        end
        bus.req_valid = 1'b0;
        repeat (2) tick();
        chk("stall_cmd", bus.command, {1'b0, 31'h100});
        chk("stall_valid", bus.valid, 1);
        push(0, 31'h199, wdat(99));
        bus.ba_cmd_pm = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        chk("full_pop_ready", bus.req_ready, 1);
        for (int k = 1; k < 8; k++) begin
            chk($sformatf("drain%0d_valid", k), bus.valid, 1);
            chk($sformatf("drain%0d_cmd", k), bus.command, {1'b0, 31'h100 + 31'(k)});
            chk($sformatf("drain%0d_wd", k), bus.write_data, wdat(k));
            tick();
        end
        chk("drained_valid", bus.valid, 0);
        for (int k = 0; k < 3; k++) begin
            push(0, 31'h200 + 31'(k), wdat(20 + k));
            tick();
            chk($sformatf("wrap%0d_cmd", k), bus.command, {1'b0, 31'h200 + 31'(k)});
            chk($sformatf("wrap%0d_wd", k), bus.write_data, wdat(20 + k));
        end
        bus.req_valid = 1'b0;
        tick();
        chk("wrap_end_valid", bus.valid, 0);

        // Read cap: five reads, four issue, one return releases the fifth
        for (int k = 0; k < 5; k++) begin
            push(1, 31'h40 + 31'(k), '0);
            tick();
        end
        bus.req_valid = 1'b0;
        repeat (2) tick();
        chk("cap_valid", bus.valid, 0);
        chk("cap_out", bus.rd_outstanding, 4);
        chk("cap_cmd", bus.command, {1'b1, 31'h44});
        chk("cap_wd", bus.write_data, 0);
        bus.read_data_valid = 1'b1;
        bus.read_data       = 128'hA0;
        tick();
        bus.read_data_valid = 1'b0;
        chk("ret_out", bus.rd_outstanding, 3);
        chk("ret_valid", bus.valid, 1);
        chk("ret_rspv", bus.rsp_valid, 1);
        chk("ret_rspd", bus.rsp_data, 128'hA0);
        tick();
        chk("fifth_out", bus.rd_outstanding, 4);
        chk("fifth_valid", bus.valid, 0);
        chk("fifth_cmd", bus.command, 0);
        chk("fifth_rspv", bus.rsp_valid, 0);
        for (int k = 0; k < 4; k++) begin
            bus.read_data_valid = 1'b1;
            bus.read_data       = 128'hB0 + 128'(k);
            tick();
            chk($sformatf("rsp%0d_v", k), bus.rsp_valid, 1);
            chk($sformatf("rsp%0d_d", k), bus.rsp_data, 128'hB0 + 128'(k));
            chk($sformatf("rsp%0d_out", k), bus.rd_outstanding, 3'(3 - k));
        end
        bus.read_data_valid = 1'b0;
        tick();
        chk("rsp_end_v", bus.rsp_valid, 0);
        chk("rsp_end_d", bus.rsp_data, 128'hB3);
        chk("rsp_end_err", bus.err_unexp_rd, 0);

        // Mid-operation reset with one read outstanding and three queued writes
        push(1, 31'h60, '0);
        tick();
        bus.req_valid = 1'b0;
        tick();
        bus.ba_cmd_pm = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push(0, 31'h70 + 31'(k), wdat(70 + k));
            tick();
        end
        idle_inputs();
        chk("pre_rst_out", bus.rd_outstanding, 1);
        chk("pre_rst_valid", bus.valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.valid, 0);
        chk("mid_rst_cmd", bus.command, 0);
        chk("mid_rst_wd", bus.write_data, 0);
        chk("mid_rst_ready", bus.req_ready, 0);
        chk("mid_rst_out", bus.rd_outstanding, 0);
        chk("mid_rst_rspd", bus.rsp_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", bus.req_ready, 1);
        chk("post_rst_valid", bus.valid, 0);
        bus.ba_cmd_pm = 1'b1;
        repeat (3) tick();
        chk("post_rst_noreplay", bus.valid, 0);
        chk("post_rst_out", bus.rd_outstanding, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
